// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner with single-cycle multiply and 32-step restoring divide.
// Define HILO_MUL_ITER_EN to run MULT/MULTU through a 32-step shift-add datapath instead.
module hilo_muldiv_unit #(
  parameter int unsigned ITER_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata
);

  localparam int unsigned W        = 32;
  localparam int unsigned CNT_W    = $clog2(ITER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_MUL = 2'd2, S_DONE = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [W-1:0]     acc_hi, acc_hi_nxt, acc_lo, acc_lo_nxt, opnd, opnd_nxt;
  logic             q_neg, q_neg_nxt, r_neg, r_neg_nxt, dz, dz_nxt;
  logic [W-1:0]     hi, hi_nxt, lo, lo_nxt;

  // Operand decode: magnitudes for signed ops, raw values for unsigned ones
  logic         is_signed;
  logic [W-1:0] abs_a, abs_b;
  assign is_signed = (req_op == OP_MULT) || (req_op == OP_DIV);
  assign abs_a = (is_signed && src_a[W-1]) ? (~src_a + 32'd1) : src_a;
  assign abs_b = (is_signed && src_b[W-1]) ? (~src_b + 32'd1) : src_b;

`ifndef HILO_MUL_ITER_EN
  logic [2*W-1:0] ext_a, ext_b, product;
  assign ext_a   = {{W{is_signed & src_a[W-1]}}, src_a};
  assign ext_b   = {{W{is_signed & src_b[W-1]}}, src_b};
  assign product = ext_a * ext_b;
`endif

  // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
  logic [W:0]   div_shift, div_diff;
  logic         div_ok;
  logic [W-1:0] div_hi, div_lo;
  assign div_shift = {acc_hi, acc_lo[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = ~div_diff[W];
  assign div_hi    = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
  assign div_lo    = {acc_lo[W-2:0], div_ok};

`ifdef HILO_MUL_ITER_EN
  // Shift-add multiply step: acc_lo holds the multiplier, product bits enter from the top
  logic [W:0]     mul_sum;
  logic [W-1:0]   mul_hi, mul_lo;
  logic [2*W-1:0] mul_res;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign mul_hi  = mul_sum[W:1];
  assign mul_lo  = {mul_sum[0], acc_lo[W-1:1]};
  assign mul_res = q_neg ? (~{mul_hi, mul_lo} + 64'd1) : {mul_hi, mul_lo};
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    opnd_nxt   = opnd;
    q_neg_nxt  = q_neg;
    r_neg_nxt  = r_neg;
    dz_nxt     = dz;
    hi_nxt     = hi;
    lo_nxt     = lo;
    stall      = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_MTHI: hi_nxt = src_a;
            OP_MTLO: lo_nxt = src_a;
            OP_DIV, OP_DIVU: begin
              stall      = ~flush;
              state_nxt  = S_DIV;
              cnt_nxt    = '0;
              acc_hi_nxt = '0;
              acc_lo_nxt = abs_a;
              opnd_nxt   = abs_b;
              q_neg_nxt  = is_signed & (src_a[W-1] ^ src_b[W-1]);
              r_neg_nxt  = is_signed & src_a[W-1];
              dz_nxt     = (src_b == '0);
            end
            OP_MULT, OP_MULTU: begin
`ifdef HILO_MUL_ITER_EN
              stall      = ~flush;
              state_nxt  = S_MUL;
              cnt_nxt    = '0;
              acc_hi_nxt = '0;
              acc_lo_nxt = abs_b;
              opnd_nxt   = abs_a;
              q_neg_nxt  = is_signed & (src_a[W-1] ^ src_b[W-1]);
              r_neg_nxt  = 1'b0;
              dz_nxt     = 1'b0;
`else
              {hi_nxt, lo_nxt} = product;
`endif
            end
            default: ;
          endcase
        end
      end
      S_DIV: begin
        stall      = 1'b1;
        busy       = 1'b1;
        cnt_nxt    = cnt + CNT_W'(1);
        acc_hi_nxt = div_hi;
        acc_lo_nxt = div_lo;
        // Divide by zero keeps the all-ones quotient unnegated; remainder fix-up restores src_a
        if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
          hi_nxt    = r_neg ? (~div_hi + 32'd1) : div_hi;
          lo_nxt    = (q_neg && !dz) ? (~div_lo + 32'd1) : div_lo;
        end
      end
`ifdef HILO_MUL_ITER_EN
      S_MUL: begin
        stall      = 1'b1;
        busy       = 1'b1;
        cnt_nxt    = cnt + CNT_W'(1);
        acc_hi_nxt = mul_hi;
        acc_lo_nxt = mul_lo;
        if (cnt == CNT_LAST) begin
          state_nxt        = S_DONE;
          {hi_nxt, lo_nxt} = mul_res;
        end
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Flush wins over everything, including MTHI/MTLO and a final-step write
    if (flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      hi_nxt    = hi;
      lo_nxt    = lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc_hi <= acc_hi_nxt;
      acc_lo <= acc_lo_nxt;
      opnd   <= opnd_nxt;
      q_neg  <= q_neg_nxt;
      r_neg  <= r_neg_nxt;
      dz     <= dz_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
    end
  end

  assign hi_rdata = hi;
  assign lo_rdata = lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases plus random ops vs an arithmetic model.
// Honours HILO_MUL_ITER_EN for the expected multiply latency.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid;
  logic [2:0]  req_op;
  logic [31:0] src_a, src_b;
  logic        stall, busy;
  logic [31:0] hi_rdata, lo_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo;

`ifdef HILO_MUL_ITER_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 0;
`endif

  hilo_muldiv_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI,LO} from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
    longint sa, sb;
    logic [63:0] ua, ub;
    int da, db, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    da = int'(a);
    db = int'(b);
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = da / db;
        r = da % db;
        return {32'(r), 32'(q)};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd5: return {a, lo};
      3'd6: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int n, exp_lat;
    logic [63:0] r;
    r = ref_result(op, a, b, m_hi, m_lo);
    exp_lat = (op == 3'd3 || op == 3'd4) ? 33 : ((op == 3'd1 || op == 3'd2) ? MUL_LAT : 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 60) begin
      n++;
      @(posedge clk); #2;
      if (n == 1) chk({tag, " busy_first_iter"}, 64'(busy), 64'(exp_lat != 0));
    end
    chk({tag, " stall_cycles"}, 64'(n), 64'(exp_lat));
    if (n == 0) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_op = 3'd0;
    #1;
    {m_hi, m_lo} = r;
    chk({tag, " hi"}, 64'(hi_rdata), 64'(m_hi));
    chk({tag, " lo"}, 64'(lo_rdata), 64'(m_lo));
    chk({tag, " busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0;
    src_a = 32'd0; src_b = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset hi", 64'(hi_rdata), 64'd0);
    chk("reset lo", 64'(lo_rdata), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);

    // MTHI then MTLO on consecutive cycles
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd5; src_a = 32'h1234_5678; #1;
    chk("mthi stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    req_op = 3'd6; src_a = 32'h9ABC_DEF0; #1;
    chk("mtlo stall", 64'(stall), 64'd0);
    chk("mthi hi", 64'(hi_rdata), 64'h1234_5678);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'd0; #1;
    chk("mtlo lo", 64'(lo_rdata), 64'h9ABC_DEF0);
    chk("mtlo hi kept", 64'(hi_rdata), 64'h1234_5678);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max const", {32'(hi_rdata), 32'(lo_rdata)}, 64'hFFFF_FFFE_0000_0001);
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    chk("mult_neg const", {32'(hi_rdata), 32'(lo_rdata)}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    chk("div_neg7_2 const", {32'(hi_rdata), 32'(lo_rdata)}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'd4, 32'd100, 32'd7, "divu_100_7");
    chk("divu_100_7 const", {32'(hi_rdata), 32'(lo_rdata)}, {32'd2, 32'd14});
    do_op(3'd4, 32'h55, 32'd0, "divu_by0");
    chk("divu_by0 const", {32'(hi_rdata), 32'(lo_rdata)}, {32'h55, 32'hFFFF_FFFF});
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf const", {32'(hi_rdata), 32'(lo_rdata)}, {32'd0, 32'h8000_0000});
    do_op(3'd3, 32'hFFFF_F000, 32'd0, "div_neg_by0");
    do_op(3'd3, 32'd17, 32'hFFFF_FFFB, "div_pos_neg");
    do_op(3'd0, 32'h1111, 32'h2222, "op_none");
    do_op(3'd7, 32'h3333, 32'h4444, "op_reserved");

    // Flush in the middle of a divide
    do_op(3'd5, 32'hAAAA, 32'd0, "set_hi");
    do_op(3'd6, 32'hBBBB, 32'd0, "set_lo");
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd3; src_a = 32'd1000; src_b = 32'd3; #1;
    chk("flush div accept stall", 64'(stall), 64'd1);
    repeat (11) @(posedge clk);
    #2;
    chk("flush div busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0; req_op = 3'd0; #1;
    chk("flush stall", 64'(stall), 64'd0);
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush hi", 64'(hi_rdata), 64'hAAAA);
    chk("flush lo", 64'(lo_rdata), 64'hBBBB);

    // Flush together with requests in IDLE
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd5; src_a = 32'hDEAD; flush = 1'b1; #1;
    chk("flush mthi stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    req_op = 3'd3; src_a = 32'd9; src_b = 32'd2; #1;
    chk("flush mthi hi", 64'(hi_rdata), 64'hAAAA);
    chk("flush div idle stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0; req_op = 3'd0; #1;
    chk("flush div idle busy", 64'(busy), 64'd0);
    chk("flush div idle lo", 64'(lo_rdata), 64'hBBBB);
    do_op(3'd4, 32'd100, 32'd7, "divu_after_flush");

    // Async reset during a divide
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd3; src_a = 32'h7FFF_0000; src_b = 32'd5;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0;
    #1;
    chk("rst_mid hi", 64'(hi_rdata), 64'd0);
    chk("rst_mid lo", 64'(lo_rdata), 64'd0);
    chk("rst_mid stall", 64'(stall), 64'd0);
    chk("rst_mid busy", 64'(busy), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1 rst = 1'b0;
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_after_rst");

    // Random operations, biased towards divide corner operands
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(rop, ra, rb, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage owner and writer of the architectural HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests and computes results, iteratively for divide.
- Stalls the pipeline while busy and exposes registered HI/LO to the pipeline for MFHI/MFLO.
- The register file is the consumer of this block's hi_rdata/lo_rdata.

Parameters:
- ITER_CYCLES, 32: iteration cycles per divide (and per multiply when HILO_MUL_ITER_EN is defined). Fixed at 32; other values unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  abort any in-flight operation; no HI/LO write.
- req_valid  input  1  request presented this cycle; held high by the pipeline while stall=1.
- req_op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- src_a  input  32  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- src_b  input  32  rt operand: divisor or multiplier.
- stall  output  1  pipeline hold request.
- busy  output  1  high in MUL or DIV state.
- hi_rdata  output  32  current HI register.
- lo_rdata  output  32  current LO register.

Behaviour:
- Reset (async, rst=1):
  - HI=0, LO=0, state=IDLE, counter=0, stall=0, busy=0.
  - Reset mid-operation discards the operation.
- hi_rdata/lo_rdata are the registers themselves, with no bypass. A write at edge N is visible from cycle N+1.
- States: IDLE, DIV, MUL (only with HILO_MUL_ITER_EN), DONE.
- IDLE:
  - req_valid & MTHI: HI<=src_a at the edge; stall=0.
  - req_valid & MTLO: LO<=src_a at the edge; stall=0.
  - req_valid & DIV/DIVU:
    - stall=1 combinationally in the same cycle.
    - Capture |src_a|, |src_b| (raw values for DIVU), the quotient sign (a31^b31) and the remainder sign (a31).
    - Go to DIV with counter=0.
  - MULT/MULTU without the macro: single-cycle product, {HI,LO}<=product at the edge, stall=0.
- DIV:
  - stall=1, busy=1.
  - One restoring shift-subtract step per cycle.
  - At the edge where counter==31: write LO=quotient and HI=remainder (sign-corrected for DIV), then go to DONE.
- DONE:
  - stall=0, busy=0.
  - req_valid is ignored because it is the same held instruction.
  - Next state is IDLE.
- Divide latency: stall is high for exactly 33 cycles (accept cycle + 32 iterations). Result is readable in the DONE cycle.
- Arithmetic:
  - Signed results truncate toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
  - Divide by zero (DIV or DIVU) gives LO=0xFFFFFFFF, HI=src_a.
  - MULT is signed 32x32->64; MULTU is unsigned.
- flush:
  - Takes priority over everything. Returns to IDLE at the next edge, writes no HI/LO, stall=0 in the following cycle.
  - flush together with a request in IDLE: the request is not accepted and no HI/LO write occurs (including MTHI/MTLO).
- req_op=0 or 7: no effect.

Optional Feature:
- HILO_MUL_ITER_EN.
- Defined:
  - MULT/MULTU use a 32-cycle shift-add datapath through the MUL state, with the same stall/DONE timing as divide (33 stall cycles).
  - Signed operands are handled by magnitude plus sign fix.
- Undefined:
  - Single-cycle multiply in IDLE, no MUL state, stall never asserted for multiply.
  - Results are bit-identical to the defined case.

Test Plan:
- Reset: rst pulse mid-DIV -> HI=LO=0, stall=0 immediately (async); next DIV runs normally.
- MTHI then MTLO: MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi_rdata=0x12345678 the cycle after the first, lo_rdata=0x9ABCDEF0 the cycle after the second; stall never high.
- Multiply:
  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
  - MULT 0xFFFFFFFE*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Check both builds: 1-cycle latency without the macro, 33 stall cycles with it.
- Divide:
  - DIV 0xFFFFFFF9/2 (-7/2) -> stall high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100/7 -> LO=14, HI=2.
- Edge divides:
  - DIVU 0x55/0 -> LO=0xFFFFFFFF, HI=0x55.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Flush: HI=0xAAAA, LO=0xBBBB, start DIV, assert flush in iteration 10 -> stall=0 the next cycle, HI/LO unchanged; a new DIVU is then accepted normally.
